// File: rtl/element_delay_accumulator.sv
// Turns per-element K_n terms into absolute integer sample delays for both array halves,
// tracking an integer delay and a fixed-point residual per half.
module element_delay_accumulator #(
  parameter int DW_INTEGER   = 18,
  parameter int DW_FRACTION  = 6,
  parameter int DW_DELAY     = 12,
  parameter int NUM_ELEMENTS = 64,
  parameter int MAX_STEPS    = 15
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      initiate,
  input  logic        [DW_DELAY-1:0]                init_delay,
  input  logic                                      term_ready,
  input  logic signed [DW_INTEGER+DW_FRACTION-1:0]  term_pos_n,
  input  logic signed [DW_INTEGER+DW_FRACTION-1:0]  term_neg_n,
  input  logic                                      term_last,
  output logic                                      term_ack,
  output logic        [DW_DELAY-1:0]                delay_pos,
  output logic        [DW_DELAY-1:0]                delay_neg,
  output logic        [$clog2(NUM_ELEMENTS/2):0]    delay_index,
  output logic                                      delay_valid,
  input  logic                                      delay_ack,
  output logic                                      done,
  output logic                                      busy,
  output logic                                      overflow
);

  localparam int TW  = DW_INTEGER + DW_FRACTION;
  localparam int EW  = TW + 1;
  localparam int IW  = $clog2(NUM_ELEMENTS/2) + 1;
  localparam int SCW = $clog2(MAX_STEPS + 1);
  localparam int PAD = EW - DW_DELAY - 1 - DW_FRACTION;
  localparam logic signed [EW-1:0] UNIT = EW'(2 ** DW_FRACTION);

  typedef enum logic [2:0] {IDLE, FETCH, STEP, OUTPUT, DONE} state_t;

  typedef struct packed {
    logic        [DW_DELAY-1:0] t;
    logic signed [EW-1:0]       e;
    logic                       settled;
    logic                       ovf;
  } half_t;

  state_t               state;
  logic [DW_DELAY-1:0]  t_pos, t_neg;
  logic signed [EW-1:0] e_pos, e_neg;
  logic [IW-1:0]        idx;
  logic [SCW-1:0]       step_cnt;
  logic                 last_q;
  half_t                sp, sn;

  // One compare-and-step of a half: moving t by one consumes (t+d)^2 - t^2 from e.
  function automatic half_t step_half(input logic [DW_DELAY-1:0] t,
                                      input logic signed [EW-1:0] e);
    half_t r;
    logic signed [EW-1:0] up_thr;
    logic signed [EW-1:0] dn_thr;
    up_thr    = $signed({{PAD{1'b0}}, t, 1'b1, {DW_FRACTION{1'b0}}});
    dn_thr    = up_thr - (UNIT + UNIT);
    r.t       = t;
    r.e       = e;
    r.settled = 1'b0;
    r.ovf     = 1'b0;
    if (e >= up_thr) begin
      if (&t) begin
        r.settled = 1'b1;
        r.ovf     = 1'b1;
      end else begin
        r.t = t + 1'b1;
        r.e = e - up_thr;
      end
    end else if ((t != '0) && (e <= -dn_thr)) begin
      r.t = t - 1'b1;
      r.e = e + dn_thr;
    end else begin
      r.settled = 1'b1;
      if ((t == '0) && (e <= -UNIT)) r.ovf = 1'b1;
    end
    return r;
  endfunction

  assign sp = step_half(t_pos, e_pos);
  assign sn = step_half(t_neg, e_neg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      t_pos       <= '0;
      t_neg       <= '0;
      e_pos       <= '0;
      e_neg       <= '0;
      idx         <= '0;
      step_cnt    <= '0;
      last_q      <= 1'b0;
      term_ack    <= 1'b0;
      delay_pos   <= '0;
      delay_neg   <= '0;
      delay_index <= '0;
      delay_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      term_ack <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (initiate) begin
            t_pos    <= init_delay;
            t_neg    <= init_delay;
            e_pos    <= '0;
            e_neg    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (term_ready) begin
            e_pos    <= e_pos + $signed({term_pos_n[TW-1], term_pos_n});
            e_neg    <= e_neg + $signed({term_neg_n[TW-1], term_neg_n});
            last_q   <= term_last;
            idx      <= idx + IW'(1);
            step_cnt <= '0;
            term_ack <= 1'b1;
            state    <= STEP;
          end
        end
        STEP: begin
          if (sp.ovf || sn.ovf) overflow <= 1'b1;
          if (sp.settled && sn.settled) begin
            delay_pos   <= t_pos;
            delay_neg   <= t_neg;
            delay_index <= idx;
            delay_valid <= 1'b1;
            state       <= OUTPUT;
          end else if (step_cnt == SCW'(MAX_STEPS)) begin
            // Step budget exhausted: publish the partially converged delays.
            overflow    <= 1'b1;
            delay_pos   <= t_pos;
            delay_neg   <= t_neg;
            delay_index <= idx;
            delay_valid <= 1'b1;
            state       <= OUTPUT;
          end else begin
            t_pos    <= sp.t;
            e_pos    <= sp.e;
            t_neg    <= sn.t;
            e_neg    <= sn.e;
            step_cnt <= step_cnt + SCW'(1);
          end
        end
        OUTPUT: begin
          if (delay_ack) begin
            delay_valid <= 1'b0;
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_element_delay_accumulator.sv
// [TB] Directed bench for element_delay_accumulator: expected delays are queued when a
// term is driven and compared when delay_valid appears.
module tb_element_delay_accumulator;

  typedef struct {
    int pos;
    int neg;
    int idx;
    int lat;
    int ovf;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               initiate = 1'b0;
  logic        [11:0] init_delay = '0;
  logic               term_ready = 1'b0;
  logic signed [23:0] term_pos_n = '0;
  logic signed [23:0] term_neg_n = '0;
  logic               term_last = 1'b0;
  logic               term_ack;
  logic        [11:0] delay_pos;
  logic        [11:0] delay_neg;
  logic        [5:0]  delay_index;
  logic               delay_valid;
  logic               delay_ack = 1'b0;
  logic               done;
  logic               busy;
  logic               overflow;

  int   cmp_cnt  = 0;
  int   fail_cnt = 0;
  int   ack_cnt  = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  element_delay_accumulator dut (
    .clk(clk), .rst(rst), .initiate(initiate), .init_delay(init_delay),
    .term_ready(term_ready), .term_pos_n(term_pos_n), .term_neg_n(term_neg_n),
    .term_last(term_last), .term_ack(term_ack), .delay_pos(delay_pos),
    .delay_neg(delay_neg), .delay_index(delay_index), .delay_valid(delay_valid),
    .delay_ack(delay_ack), .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (term_ack) ack_cnt++;
    if (done) done_cnt++;
  end

  function automatic logic signed [23:0] q(input int v);
    return 24'(v * 64);
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doInitiate(input int d);
    @(negedge clk);
    initiate   = 1'b1;
    init_delay = 12'(d);
    @(negedge clk);
    initiate = 1'b0;
    checkValue("busy_after_init", 32'(busy), 32'd1);
    checkValue("ovf_after_init", 32'(overflow), 32'd0);
  endtask

  // Drive one term, queue its expected result, and wait (bounded) for term_ack.
  task automatic applyStimulus(input int pos, input int neg, input bit last,
                               input int ep, input int en, input int ei,
                               input int lat, input int ovf);
    int n;
    exp_t e;
    e.pos = ep; e.neg = en; e.idx = ei; e.lat = lat; e.ovf = ovf;
    sb.push_back(e);
    term_pos_n = q(pos);
    term_neg_n = q(neg);
    term_last  = last;
    term_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!term_ack && n < 100);
    term_ready = 1'b0;
    checkValue("term_ack_seen", 32'(term_ack), 32'd1);
  endtask

  // Wait for delay_valid (bounded), then pop and compare against the scoreboard.
  task automatic checkOutput(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!delay_valid && n < 100);
    checkValue({tag, "_valid"}, 32'(delay_valid), 32'd1);
    checkValue({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkValue({tag, "_latency"}, 32'(n), 32'(e.lat));
      checkValue({tag, "_pos"}, 32'(delay_pos), 32'(e.pos));
      checkValue({tag, "_neg"}, 32'(delay_neg), 32'(e.neg));
      checkValue({tag, "_index"}, 32'(delay_index), 32'(e.idx));
      checkValue({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  task automatic ackOutput(input bit expect_done);
    delay_ack = 1'b1;
    @(negedge clk);
    delay_ack = 1'b0;
    checkValue("valid_dropped", 32'(delay_valid), 32'd0);
    checkValue("done_pulse", 32'(done), 32'(expect_done));
    if (expect_done) begin
      @(negedge clk);
      checkValue("done_cleared", 32'(done), 32'd0);
      checkValue("idle_not_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int   acks0;
    int   dones0;
    bit   stable;
    logic [11:0] hp, hn;
    logic [5:0]  hi;

    $display("[TB] start");
    #1 rst = 1'b1;
    #2;
    checkValue("rst_term_ack", 32'(term_ack), 32'd0);
    checkValue("rst_valid", 32'(delay_valid), 32'd0);
    checkValue("rst_done", 32'(done), 32'd0);
    checkValue("rst_busy", 32'(busy), 32'd0);
    checkValue("rst_ovf", 32'(overflow), 32'd0);
    checkValue("rst_pos", 32'(delay_pos), 32'd0);
    checkValue("rst_neg", 32'(delay_neg), 32'd0);
    checkValue("rst_index", 32'(delay_index), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // One increment on the positive half, one decrement on the negative half.
    doInitiate(100);
    applyStimulus(201, -199, 1'b1, 101, 99, 1, 2, 0);
    checkOutput("stepup");
    ackOutput(1'b1);

    // Residual from term 1 (72 - 21 - 23 - 25 = 3) must carry into term 2.
    doInitiate(10);
    applyStimulus(72, 0, 1'b0, 13, 10, 1, 4, 0);
    checkOutput("multi1");
    ackOutput(1'b0);
    applyStimulus(24, 21, 1'b1, 14, 11, 2, 2, 0);
    checkOutput("multi2");
    ackOutput(1'b1);

    // Abort in the middle of a three-step update.
    dones0 = done_cnt;
    doInitiate(10);
    applyStimulus(72, 0, 1'b1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkValue("midrst_pos", 32'(delay_pos), 32'd0);
    checkValue("midrst_valid", 32'(delay_valid), 32'd0);
    checkValue("midrst_busy", 32'(busy), 32'd0);
    checkValue("midrst_index", 32'(delay_index), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("midrst_no_done", 32'(done_cnt), 32'(dones0));
    doInitiate(7);
    applyStimulus(0, 0, 1'b1, 7, 7, 1, 1, 0);
    checkOutput("clean");
    ackOutput(1'b1);

    // Full sweep of zero terms; a stray initiate mid-sweep must be ignored.
    acks0  = ack_cnt;
    dones0 = done_cnt;
    doInitiate(500);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(0, 0, (i == 32), 500, 500, i, 1, 0);
      checkOutput("zero");
      if (i == 1) begin
        delay_ack = 1'b1;
        @(negedge clk);
        delay_ack  = 1'b0;
        initiate   = 1'b1;
        init_delay = 12'd999;
        @(negedge clk);
        initiate = 1'b0;
      end else begin
        ackOutput(i == 32);
      end
    end
    checkValue("zero_ack_count", 32'(ack_cnt - acks0), 32'd32);
    checkValue("zero_done_count", 32'(done_cnt - dones0), 32'd1);

    // Backpressure: next term presented while the output is held unacknowledged.
    doInitiate(300);
    applyStimulus(601, 0, 1'b0, 301, 300, 1, 2, 0);
    checkOutput("bp1");
    acks0      = ack_cnt;
    hp         = delay_pos;
    hn         = delay_neg;
    hi         = delay_index;
    stable     = 1'b1;
    term_pos_n = q(-601);
    term_neg_n = q(0);
    term_last  = 1'b1;
    term_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!delay_valid || delay_pos !== hp || delay_neg !== hn || delay_index !== hi)
        stable = 1'b0;
    end
    checkValue("bp_stable", 32'(stable), 32'd1);
    checkValue("bp_no_ack", 32'(ack_cnt - acks0), 32'd0);
    ackOutput(1'b0);
    applyStimulus(-601, 0, 1'b1, 300, 300, 2, 2, 0);
    checkOutput("bp2");
    ackOutput(1'b1);

    // Increment requested at the top of the delay range.
    doInitiate(4095);
    applyStimulus(8191, 0, 1'b1, 4095, 4095, 1, 1, 1);
    checkOutput("sat");
    ackOutput(1'b1);

    // Far-off term runs out of step budget.
    doInitiate(0);
    applyStimulus(8191, 0, 1'b1, 15, 0, 1, 16, 1);
    checkOutput("limit");
    ackOutput(1'b1);

    // Negative residual with the delay already at zero.
    doInitiate(0);
    applyStimulus(0, -1, 1'b1, 0, 0, 1, 1, 1);
    checkOutput("under");
    ackOutput(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
